// File: rtl/ram8.sv
// Eight-word RAM: per-bit mux-fed flops, 1-to-8 load demux,
// and an 8-to-1 read mux tree. Combinational read, sync reset.

module ram8_cell (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic sel,
  output logic q
);

  logic nxt;

  assign nxt = sel ? d : q;

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= nxt;
  end

endmodule

module ram8_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ram8_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .d    (d[i]),
      .sel  (load),
      .q    (q[i])
    );
  end

endmodule

module ram8_dmux #(
  parameter int ADDR_W = 3
) (
  input  logic                   load,
  input  logic [ADDR_W-1:0]      address,
  output logic [(1<<ADDR_W)-1:0] sel
);

  always_comb begin
    sel = '0;
    if (load) sel[address] = 1'b1;
  end

endmodule

module ram8_mux #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic [WIDTH-1:0]  words [1<<ADDR_W],
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int DEPTH = 1 << ADDR_W;

  // Binary tree: level 0 holds the words, each level halves on one address bit.
  logic [WIDTH-1:0] lvl [ADDR_W+1][DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_leaf
    assign lvl[0][k] = words[k];
  end

  for (genvar l = 0; l < ADDR_W; l++) begin : g_lvl
    for (genvar k = 0; k < DEPTH; k++) begin : g_node
      if (k < (DEPTH >> (l + 1))) begin : g_used
        assign lvl[l+1][k] = address[l] ? lvl[l][2*k+1] : lvl[l][2*k];
      end else begin : g_unused
        assign lvl[l+1][k] = '0;
      end
    end
  end

  assign out = lvl[ADDR_W][0];

endmodule

module ram8 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] word_load;
  logic [WIDTH-1:0] words [DEPTH];

  ram8_dmux #(.ADDR_W(ADDR_W)) u_dmux (
    .load   (load),
    .address(address),
    .sel    (word_load)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    ram8_reg #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .reset(reset),
      .d    (in),
      .load (word_load[k]),
      .q    (words[k])
    );
  end

  ram8_mux #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mux (
    .words  (words),
    .address(address),
    .out    (out)
  );

endmodule
